// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the USB full-speed receive path.
package usb_rx_pkg;

    // Bit-timer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } rx_state_e;

    // 96 MHz system clock over a 12 Mbps bit rate
    localparam int unsigned DEF_CLKS_PER_BIT = 8;
    // Clock index within a bit where D+ is sampled
    localparam int unsigned DEF_SAMPLE_POINT = 3;
    // Data bits per byte counter width
    localparam int unsigned BIT_CNT_W        = 3;

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter with synchronous clear and programmable rollover back to zero.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Next count: clear wins over increment; wrap to zero after rollover_val
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/usb_rx_timer.sv
// Recovers bit timing from D+ edges: produces the sample strobe and the byte-complete pulse.
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_POINT = DEF_SAMPLE_POINT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic stuff_bit,
    output logic shift_enable,
    output logic byte_received
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] ROLL_VAL   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_VAL = CNT_W'(SAMPLE_POINT);

    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d;
    logic                   byte_received_q;
    logic                   byte_received_d;
    logic [CNT_W-1:0]       clk_cnt;
    logic                   cnt_clear;
    logic                   cnt_enable;
    logic                   data_shift;

    // Next state: dropping rcving returns to IDLE regardless of any edge
    always_comb begin
        state_d = state_q;
        if (!rcving) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: if (d_edge) state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Clock-in-bit counter: runs in RUN, restarts at zero on every edge or outside RUN
    always_comb begin
        cnt_enable = (state_q == ST_RUN);
        cnt_clear  = (state_d != ST_RUN) || d_edge;
    end

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_clk_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_enable),
        .rollover_val (ROLL_VAL),
        .count_out    (clk_cnt)
    );

    // Sample strobe decoded purely from registered state and count
    assign shift_enable = (state_q == ST_RUN) && (clk_cnt == SAMPLE_VAL);

    // Data bits exclude stuffed bits
    assign data_shift = shift_enable && !stuff_bit;

    // Bit counter and byte-complete decode; both abandon a partial byte on leaving RUN
    always_comb begin
        bit_cnt_d       = bit_cnt_q;
        byte_received_d = 1'b0;
        if (state_d != ST_RUN) begin
            bit_cnt_d = '0;
        end else if (data_shift) begin
            bit_cnt_d       = bit_cnt_q + BIT_CNT_W'(1);
            byte_received_d = (bit_cnt_q == {BIT_CNT_W{1'b1}});
        end
    end

    // State, bit counter and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            byte_received_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_received_q <= byte_received_d;
        end
    end

    assign byte_received = byte_received_q;

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer with a cycle-level reference model and literal pulse-time checks.
module tb_usb_rx_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic rcving = 1'b0;
    logic d_edge = 1'b0;
    logic stuff_bit = 1'b0;
    logic shift_enable;
    logic byte_received;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int se_q[$];
    int br_q[$];

    // Reference model state (for the cycle currently being checked)
    int m_run = 0;
    int m_armed = 0;
    int m_edge = 0;
    int m_bits = 0;
    int m_br = 0;

    usb_rx_timer #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rcving        (rcving),
        .d_edge        (d_edge),
        .stuff_bit     (stuff_bit),
        .shift_enable  (shift_enable),
        .byte_received (byte_received)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0b expected=%0b", name, cyc - t0, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Compare every cycle against the model, then advance the model with this cycle's inputs
    always @(posedge clk) begin
        logic exp_se;
        cyc++;
        #1;
        exp_se = 1'b0;
        if (m_run != 0) exp_se = (((cyc - m_edge - 1) % CPB) == SP);
        chk("shift_enable", shift_enable, exp_se);
        chk("byte_received", byte_received, m_br != 0);
        if (shift_enable === 1'b1) se_q.push_back(cyc - t0);
        if (byte_received === 1'b1) br_q.push_back(cyc - t0);
        @(negedge clk);
        if (!n_rst) begin
            m_run = 0; m_armed = 0; m_bits = 0; m_br = 0;
        end else begin
            m_br = 0;
            if (exp_se && !stuff_bit) begin
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    m_br = rcving ? 1 : 0;
                end
            end
            if (!rcving) begin
                m_run = 0; m_armed = 0; m_bits = 0;
            end else if (d_edge && (m_armed != 0 || m_run != 0)) begin
                m_run = 1;
                m_edge = cyc;
            end else if (m_run == 0) begin
                m_armed = 1;
            end
        end
    end

    // Reset pulse between clocks; scenario cycle 0 is the cycle reset is released in
    task automatic start_scn();
        @(posedge clk); #2;
        n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; stuff_bit = 1'b0;
        #1;
        chk("rst_shift_enable", shift_enable, 1'b0);
        chk("rst_byte_received", byte_received, 1'b0);
        @(posedge clk); #2;
        n_rst = 1'b1;
        t0 = cyc;
        se_q.delete();
        br_q.delete();
    endtask

    task automatic at(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk); #2;
        end
    endtask

    function automatic int se_at(input int i);
        return (i < se_q.size()) ? se_q[i] : -1;
    endfunction

    function automatic int br_at(input int i);
        return (i < br_q.size()) ? br_q[i] : -1;
    endfunction

    initial begin
        // Basic timing: single edge at 10
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1;
        at(11); d_edge = 1'b0;
        at(80);
        chk_int("basic_se0", se_at(0), 14);
        chk_int("basic_se1", se_at(1), 22);
        chk_int("basic_se7", se_at(7), 70);
        chk_int("basic_se_count", se_q.size(), 9);
        chk_int("basic_br_count", br_q.size(), 1);
        chk_int("basic_br0", br_at(0), 71);

        // Resync on a second edge
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1;
        at(11); d_edge = 1'b0;
        at(16); d_edge = 1'b1;
        at(17); d_edge = 1'b0;
        at(30);
        chk_int("resync_count", se_q.size(), 3);
        chk_int("resync_se0", se_at(0), 14);
        chk_int("resync_se1", se_at(1), 20);
        chk_int("resync_se2", se_at(2), 28);

        // Edge coincident with the sample point
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1;
        at(11); d_edge = 1'b0;
        at(14); d_edge = 1'b1;
        at(15); d_edge = 1'b0;
        at(28);
        chk_int("coinc_count", se_q.size(), 3);
        chk_int("coinc_se0", se_at(0), 14);
        chk_int("coinc_se1", se_at(1), 18);
        chk_int("coinc_se2", se_at(2), 26);

        // Stuffed 3rd bit delays the byte by one bit period
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1;
        at(11); d_edge = 1'b0;
        at(30); stuff_bit = 1'b1;
        at(31); stuff_bit = 1'b0;
        at(90);
        chk_int("stuff_br_count", br_q.size(), 1);
        chk_int("stuff_br0", br_at(0), 79);

        // Partial byte discarded when rcving drops
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1;
        at(11); d_edge = 1'b0;
        at(48); rcving = 1'b0;
        at(50); rcving = 1'b1;
        at(60); d_edge = 1'b1;
        at(61); d_edge = 1'b0;
        at(125);
        chk_int("partial_br_count", br_q.size(), 1);
        chk_int("partial_br0", br_at(0), 121);

        // rcving=0 beats d_edge in SYNC
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1; rcving = 1'b0;
        at(11); d_edge = 1'b0;
        at(12); rcving = 1'b1;
        at(40);
        chk_int("prio_se_count", se_q.size(), 0);
        chk_int("prio_br_count", br_q.size(), 0);

        // Asynchronous reset mid-byte, then a fresh packet
        start_scn();
        at(2);  rcving = 1'b1;
        at(10); d_edge = 1'b1;
        at(11); d_edge = 1'b0;
        at(38);
        chk("pre_rst_shift_enable", shift_enable, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("async_rst_shift_enable", shift_enable, 1'b0);
        chk("async_rst_byte_received", byte_received, 1'b0);
        at(40); n_rst = 1'b1;
        at(50); d_edge = 1'b1;
        at(51); d_edge = 1'b0;
        at(115);
        chk_int("arst_br_count", br_q.size(), 1);
        chk_int("arst_br0", br_at(0), 111);

        rcving = 1'b0;
        at(118);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
